traffic_gen_checker: RTL and testbench

- Parametrised, synthesizable traffic generator and in-order checker for the full-logic transmission path (main FIFO -> VCs -> destination FIFOs D0..Dn).
- Replaces hand-scripted per-cycle stimulus with a programmable FSM. It pushes self-describing words into the DUT input, drains the destination FIFOs, and checks that each destination receives its words in order.
- Sits beside the DUT in benches and on-board bring-up.

---
 rtl/tgc_pkg.sv | 23 ++
 rtl/tgc_lfsr.sv | 35 +++
 rtl/traffic_gen_checker.sv | 195 +++++++++++++++++++
 tb/tb_traffic_gen_checker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tgc_pkg.sv
// Shared types and constants for the traffic generator / in-order checker.
package tgc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StDone
  } tgc_state_e;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_RR    = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7, 5, 4, 3
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tgc_lfsr.sv
// 8-bit Fibonacci LFSR; load restores the seed, advance steps once.
module tgc_lfsr
  import tgc_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       advance_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/traffic_gen_checker.sv
// Programmable traffic generator and per-destination in-order checker.
// Define TGC_TIMEOUT_EN to build a WAIT-state watchdog that forces completion.
module traffic_gen_checker
  import tgc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 6,
  parameter int unsigned DEST_WIDTH     = 1,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter logic [7:0]  LFSR_SEED      = LFSR_SEED_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned N_DEST        = 2 ** DEST_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [1:0]                   mode_i,
  input  logic [DEST_WIDTH-1:0]        fixed_dest_i,
  input  logic [CNT_WIDTH-1:0]         num_words_i,
  input  logic                         pause_i,
  input  logic                         drain_i,
  input  logic [N_DEST*DATA_WIDTH-1:0] dut_data_i,
  input  logic [N_DEST-1:0]            dut_empty_i,
  output logic                         wr_enable_o,
  output logic [DATA_WIDTH-1:0]        data_out_o,
  output logic [N_DEST-1:0]            pop_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         mismatch_o,
  output logic [CNT_WIDTH-1:0]         sent_count_o,
  output logic [CNT_WIDTH-1:0]         recv_count_o
);

  localparam int unsigned SEQ_WIDTH = DATA_WIDTH - DEST_WIDTH;
  localparam int unsigned SUM_WIDTH = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  tgc_state_e             state_q;
  logic [CNT_WIDTH-1:0]   num_q, sent_count_q, recv_count_q;
  logic                   wr_enable_q, done_q, mismatch_q;
  logic [DATA_WIDTH-1:0]  data_out_q;
  logic [N_DEST-1:0]      pop_q;
  logic [SEQ_WIDTH-1:0]   seq_q [N_DEST];
  logic [SEQ_WIDTH-1:0]   exp_seq_q [N_DEST];
  logic [SEQ_WIDTH-1:0]   exp_seq_d [N_DEST];

  logic                   push, start_ok, timeout, any_bad, overrun;
  logic [DEST_WIDTH-1:0]  dest;
  logic [7:0]             lfsr_state;
  logic [SUM_WIDTH-1:0]   n_chk, recv_sum;
  logic [CNT_WIDTH-1:0]   recv_d;
  logic                   unused_lfsr;

  assign start_ok = (state_q == StIdle) && start_i;
  assign push     = (state_q == StSend) && !pause_i;

  tgc_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i    (clk_i),
    .rst_i    (reset_i),
    .load_i   (start_ok),
    .advance_i(push),
    .state_o  (lfsr_state)
  );

  assign unused_lfsr = ^lfsr_state[7:DEST_WIDTH];

  always_comb begin
    case (mode_i)
      MODE_RR:   dest = sent_count_q[DEST_WIDTH-1:0];
      MODE_LFSR: dest = lfsr_state[DEST_WIDTH-1:0];
      default:   dest = fixed_dest_i;
    endcase
  end

  // Reset gates the pops so nothing is drained while the checker state is cleared.
  assign pop_o = reset_i ? '0 : ({N_DEST{drain_i}} & ~dut_empty_i);

  always_comb begin
    n_chk   = '0;
    any_bad = 1'b0;
    for (int d = 0; d < N_DEST; d++) begin
      exp_seq_d[d] = exp_seq_q[d];
      if (pop_q[d]) begin
        n_chk = n_chk + SUM_WIDTH'(1);
        if (dut_data_i[d*DATA_WIDTH +: DATA_WIDTH] == {DEST_WIDTH'(d), exp_seq_q[d]}) begin
          exp_seq_d[d] = exp_seq_q[d] + SEQ_WIDTH'(1);
        end else begin
          any_bad = 1'b1;
        end
      end
    end
    recv_sum = {1'b0, recv_count_q} + n_chk;
    recv_d   = (recv_sum > {1'b0, CNT_MAX}) ? CNT_MAX : recv_sum[CNT_WIDTH-1:0];
    overrun  = (n_chk != '0) && (recv_sum > {1'b0, sent_count_q});
  end

`ifdef TGC_TIMEOUT_EN
  localparam int unsigned WDOG_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_WIDTH-1:0] wdog_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wdog_q <= '0;
    end else if (state_q != StWait || n_chk != '0) begin
      wdog_q <= '0;
    end else if (!timeout) begin
      wdog_q <= wdog_q + WDOG_WIDTH'(1);
    end
  end

  assign timeout = (wdog_q == WDOG_WIDTH'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      num_q        <= '0;
      sent_count_q <= '0;
      recv_count_q <= '0;
      wr_enable_q  <= 1'b0;
      data_out_q   <= '0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      pop_q        <= '0;
      for (int d = 0; d < N_DEST; d++) begin
        seq_q[d]     <= '0;
        exp_seq_q[d] <= '0;
      end
    end else begin
      wr_enable_q  <= 1'b0;
      done_q       <= 1'b0;
      pop_q        <= pop_o;
      recv_count_q <= recv_d;
      for (int d = 0; d < N_DEST; d++) begin
        exp_seq_q[d] <= exp_seq_d[d];
      end
      if (any_bad || overrun) begin
        mismatch_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (start_i) begin
            num_q        <= num_words_i;
            sent_count_q <= '0;
            recv_count_q <= '0;
            mismatch_q   <= 1'b0;
            for (int d = 0; d < N_DEST; d++) begin
              seq_q[d]     <= '0;
              exp_seq_q[d] <= '0;
            end
            state_q <= (num_words_i == '0) ? StDone : StSend;
          end
        end
        StSend: begin
          if (!pause_i) begin
            wr_enable_q  <= 1'b1;
            data_out_q   <= {dest, seq_q[dest]};
            seq_q[dest]  <= seq_q[dest] + SEQ_WIDTH'(1);
            sent_count_q <= (sent_count_q == CNT_MAX) ? CNT_MAX
                                                      : sent_count_q + CNT_WIDTH'(1);
            if (sent_count_q == num_q - CNT_WIDTH'(1)) begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (recv_count_q == sent_count_q) begin
            state_q <= StDone;
          end else if (timeout) begin
            mismatch_q <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_enable_o  = wr_enable_q;
  assign data_out_o   = data_out_q;
  assign busy_o       = (state_q == StSend) || (state_q == StWait);
  assign done_o       = done_q;
  assign mismatch_o   = mismatch_q;
  assign sent_count_o = sent_count_q;
  assign recv_count_o = recv_count_q;

endmodule

// File: tb/tb_traffic_gen_checker.sv
// Scoreboard bench: expected pushes queued at stimulus time, checked by a negedge monitor.
module tb_traffic_gen_checker;

  localparam int DW = 6;
  localparam int ND = 2;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            fixed_dest = 1'b0;
  logic [CW-1:0]   num_words = '0;
  logic            pause = 1'b0;
  logic            drain = 1'b1;
  logic [ND*DW-1:0] dut_data = '0;
  logic [ND-1:0]   dut_empty = '1;

  logic            wr_enable_o, busy_o, done_o, mismatch_o;
  logic [DW-1:0]   data_out_o;
  logic [ND-1:0]   pop_o;
  logic [CW-1:0]   sent_count_o, recv_count_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW:0]   fifo0 [$];
  logic [DW:0]   fifo1 [$];
  logic [DW:0]   w;
  logic [DW-1:0] rd0 = '0;
  logic [DW-1:0] rd1 = '0;

  int  cyc = 0;
  int  writes_seen = 0;
  int  run_total = 0;
  int  gaps = 0;
  int  pops0 = 0;
  int  pops1 = 0;
  int  d0_pushes = 0;
  bit  corrupt_en = 1'b0;
  int  bad_pop_cyc = -1;
  int  rise_cyc = -1;
  bit  mis_seen = 1'b0;

  traffic_gen_checker dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .mode_i      (mode),
    .fixed_dest_i(fixed_dest),
    .num_words_i (num_words),
    .pause_i     (pause),
    .drain_i     (drain),
    .dut_data_i  (dut_data),
    .dut_empty_i (dut_empty),
    .wr_enable_o (wr_enable_o),
    .data_out_o  (data_out_o),
    .pop_o       (pop_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mismatch_o  (mismatch_o),
    .sent_count_o(sent_count_o),
    .recv_count_o(recv_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ideal destination FIFOs with one-cycle read latency after pop.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo0.delete();
      fifo1.delete();
      dut_empty <= '1;
      dut_data  <= '0;
    end else begin
      cyc++;
      if (pop_o[0] && fifo0.size() > 0) begin
        w = fifo0.pop_front();
        rd0 = w[DW-1:0];
        if (w[DW]) bad_pop_cyc = cyc;
        pops0++;
      end
      if (pop_o[1] && fifo1.size() > 0) begin
        w = fifo1.pop_front();
        rd1 = w[DW-1:0];
        pops1++;
      end
      if (wr_enable_o) begin
        if (data_out_o[DW-1] == 1'b0) begin
          w[DW] = corrupt_en && (d0_pushes == 1);
          w[DW-1:0] = data_out_o ^ DW'(w[DW]);
          fifo0.push_back(w);
          d0_pushes++;
        end else begin
          fifo1.push_back({1'b0, data_out_o});
        end
      end
      dut_empty <= {fifo1.size() == 0, fifo0.size() == 0};
      dut_data  <= {rd1, rd0};
    end
  end

  // Monitor: compare every pushed word against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_enable_o) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: data_out=%b expected no write", data_out_o);
        end else begin
          check("data_out", 32'(data_out_o), 32'(exp_q.pop_front()));
        end
      end else if (busy_o && writes_seen > 0 && writes_seen < run_total) begin
        gaps++;
      end
      if (mismatch_o && !mis_seen) begin
        mis_seen = 1'b1;
        rise_cyc = cyc;
      end
    end
  end

  task automatic run(input string name, input logic [1:0] m, input logic fd,
                     input logic [CW-1:0] n, input int exp_d0, input int exp_d1,
                     input logic exp_mis, input int exp_gaps);
    int t;
    mode = m;
    fixed_dest = fd;
    num_words = n;
    run_total = exp_q.size();
    writes_seen = 0;
    gaps = 0;
    pops0 = 0;
    pops1 = 0;
    d0_pushes = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: done not seen after %0d cycles, required pulse", name, t);
    end else begin
      check({name, "_recv"}, 32'(recv_count_o), 32'(n));
      check({name, "_sent"}, 32'(sent_count_o), 32'(n));
      check({name, "_mismatch"}, 32'(mismatch_o), 32'(exp_mis));
      check({name, "_pops_d0"}, 32'(pops0), 32'(exp_d0));
      check({name, "_pops_d1"}, 32'(pops1), 32'(exp_d1));
      check({name, "_left"}, 32'(exp_q.size()), 32'd0);
      check({name, "_gaps"}, 32'(gaps), 32'(exp_gaps));
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done_o), 32'd0);
    end
  endtask

  task automatic pause_after_two();
    int n = 0;
    int t = 0;
    while (n < 2 && t < 100) begin
      @(negedge clk);
      if (wr_enable_o) n++;
      t++;
    end
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_wr_enable", 32'(wr_enable_o), 32'd0);
    check("rst_data_out", 32'(data_out_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_mismatch", 32'(mismatch_o), 32'd0);
    check("rst_sent", 32'(sent_count_o), 32'd0);
    check("rst_recv", 32'(recv_count_o), 32'd0);
    check("rst_pop", 32'(pop_o), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fixed destination 1
    exp_q.push_back(6'b100000); exp_q.push_back(6'b100001);
    exp_q.push_back(6'b100010); exp_q.push_back(6'b100011);
    run("fixed", 2'd0, 1'b1, 8'd4, 0, 4, 1'b0, 0);

    // Round-robin
    exp_q.push_back(6'b000000); exp_q.push_back(6'b100000);
    exp_q.push_back(6'b000001); exp_q.push_back(6'b100001);
    exp_q.push_back(6'b000010); exp_q.push_back(6'b100010);
    run("rr", 2'd1, 1'b0, 8'd6, 3, 3, 1'b0, 0);

    // LFSR from seed A5: low bits 1,0,1,0,0
    exp_q.push_back(6'b100000); exp_q.push_back(6'b000000);
    exp_q.push_back(6'b100001); exp_q.push_back(6'b000001);
    exp_q.push_back(6'b000010);
    run("lfsr", 2'd2, 1'b0, 8'd5, 3, 2, 1'b0, 0);

    // Reserved mode behaves as fixed
    exp_q.push_back(6'b100000); exp_q.push_back(6'b100001);
    run("mode3", 2'd3, 1'b1, 8'd2, 0, 2, 1'b0, 0);

    // Backpressure after the second word
    exp_q.push_back(6'b000000); exp_q.push_back(6'b000001);
    exp_q.push_back(6'b000010); exp_q.push_back(6'b000011);
    fork
      run("pause", 2'd0, 1'b0, 8'd4, 4, 0, 1'b0, 3);
      pause_after_two();
    join

    // Corrupt the second D0 word
    corrupt_en = 1'b1;
    mis_seen = 1'b0;
    bad_pop_cyc = -1;
    exp_q.push_back(6'b000000); exp_q.push_back(6'b100000);
    exp_q.push_back(6'b000001); exp_q.push_back(6'b100001);
    exp_q.push_back(6'b000010); exp_q.push_back(6'b100010);
    run("corrupt", 2'd1, 1'b0, 8'd6, 3, 3, 1'b1, 0);
    corrupt_en = 1'b0;
    check("corrupt_rise_cycle", 32'(rise_cyc), 32'(bad_pop_cyc + 1));
    repeat (3) @(negedge clk);
    check("corrupt_sticky", 32'(mismatch_o), 32'd1);

    // Zero length; also the start that clears mismatch
    writes_seen = 0;
    run_total = 0;
    mode = 2'd0;
    num_words = 8'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_mismatch_cleared", 32'(mismatch_o), 32'd0);
    check("zero_done_c1", 32'(done_o), 32'd0);
    check("zero_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("zero_done_c2", 32'(done_o), 32'd1);
    @(negedge clk);
    check("zero_done_c3", 32'(done_o), 32'd0);
    check("zero_sent", 32'(sent_count_o), 32'd0);

    // Reset during SEND
    for (int i = 0; i < 6; i++) exp_q.push_back(DW'(i));
    run_total = 6;
    writes_seen = 0;
    mode = 2'd0;
    fixed_dest = 1'b0;
    num_words = 8'd6;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 50 && writes_seen < 3; t++) @(negedge clk);
    check("midrst_busy_before", 32'(busy_o), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_wr_enable", 32'(wr_enable_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_pop", 32'(pop_o), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(6'b000000); exp_q.push_back(6'b000001);
    run("after_rst", 2'd0, 1'b0, 8'd2, 2, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
